// File: rtl/fpadd_issue_ctrl.sv
// Issue front-end for the FP32 adder core: screens special operands, tracks core latency
// in a fixed delay line and buffers results in order behind a credit-limited output FIFO.
module fpadd_issue_ctrl #(
    parameter int ADD_LAT    = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [2:0]  res_flags
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; ready never
    // depends on valid, and valid/data are held by the source until the transfer.
    localparam int STAGES = ADD_LAT + 1;
    localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW     = $clog2(FIFO_DEPTH + STAGES + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {C_ZERO, C_SUB, C_INF, C_NAN, C_NORM} fp_class_t;

    function automatic fp_class_t classify(input logic [31:0] x);
        fp_class_t c;
        if (x[30:23] == 8'd0) begin
            if (x[22:0] == 23'd0) c = C_ZERO;
            else                  c = C_SUB;
        end else if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 23'd0) c = C_INF;
            else                  c = C_NAN;
        end else begin
            c = C_NORM;
        end
        return c;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    fp_class_t   cls_a, cls_b;
    logic        a_zero, b_zero, core_op, accept;
    logic [31:0] byp_data;
    logic [2:0]  byp_flags;

    // Bypass result for non-normal pairs; flags are {invalid, bypass, flushed}.
    always_comb begin
        cls_a     = classify(in_a);
        cls_b     = classify(in_b);
        a_zero    = (cls_a == C_ZERO) || (cls_a == C_SUB);
        b_zero    = (cls_b == C_ZERO) || (cls_b == C_SUB);
        core_op   = (cls_a == C_NORM) && (cls_b == C_NORM);
        byp_data  = '0;
        byp_flags = {1'b0, !core_op, (cls_a == C_SUB) || (cls_b == C_SUB)};
        if (cls_a == C_NAN || cls_b == C_NAN) begin
            byp_data     = QNAN;
            byp_flags[2] = 1'b1;
        end else if (cls_a == C_INF && cls_b == C_INF && in_a[31] != in_b[31]) begin
            byp_data     = QNAN;
            byp_flags[2] = 1'b1;
        end else if (cls_a == C_INF) begin
            byp_data = in_a;
        end else if (cls_b == C_INF) begin
            byp_data = in_b;
        end else if (a_zero && b_zero) begin
            byp_data = {in_a[31] & in_b[31], 31'd0};
        end else if (a_zero) begin
            byp_data = in_b;
        end else if (b_zero) begin
            byp_data = in_a;
        end
    end

    logic [STAGES-1:0] dl_valid, dl_byp;
    logic [31:0]       dl_data  [STAGES];
    logic [2:0]        dl_flags [STAGES];
    logic [CW-1:0]     inflight, fifo_count;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < STAGES; i++) inflight = inflight + CW'(dl_valid[i]);
    end

    // Credit counts every op accepted but not yet popped, so the FIFO can never overflow.
    assign in_ready = (fifo_count + inflight) < CW'(FIFO_DEPTH);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            add_a    <= '0;
            add_b    <= '0;
            dl_valid <= '0;
            dl_byp   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dl_data[i]  <= '0;
                dl_flags[i] <= '0;
            end
        end else begin
            add_a       <= (accept && core_op) ? in_a : 32'd0;
            add_b       <= (accept && core_op) ? in_b : 32'd0;
            dl_valid[0] <= accept;
            dl_byp[0]   <= !core_op;
            dl_data[0]  <= byp_data;
            dl_flags[0] <= byp_flags;
            for (int i = 1; i < STAGES; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_byp[i]   <= dl_byp[i-1];
                dl_data[i]  <= dl_data[i-1];
                dl_flags[i] <= dl_flags[i-1];
            end
        end
    end

    logic [31:0]   fifo_data  [FIFO_DEPTH];
    logic [2:0]    fifo_flags [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    logic [31:0]   push_data;

    assign push      = dl_valid[STAGES-1];
    assign push_data = dl_byp[STAGES-1] ? dl_data[STAGES-1] : add_out;
    assign res_valid = (fifo_count != '0);
    assign pop       = res_valid && res_ready;
    assign res_data  = fifo_data[rd_ptr];
    assign res_flags = fifo_flags[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i]  <= '0;
                fifo_flags[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr]  <= push_data;
                fifo_flags[wr_ptr] <= dl_flags[STAGES-1];
                wr_ptr             <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule
